mips_debug_unit: RTL and testbench

UART-driven controller that sequences the pipelined MIPS core. It sits between the UART byte transceiver and the CPU top. It loads the program memory from host bytes and runs the core in continuous or single-step mode. After a halt or after each step, it streams a debug snapshot plus a cycle count back to the host.

---
 rtl/mips_debug_unit.sv | 229 ++++++++++++++++++++++
 tb/tb_mips_debug_unit.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_debug_unit.sv
// mips_debug_unit: UART-side sequencer for the pipelined MIPS core.
// It loads program memory from host bytes, runs the core continuously or one
// step at a time, and streams a debug snapshot plus the cycle count back to the host.
module mips_debug_unit #(
  parameter int              LEN        = 32,
  parameter int              ADDR_LEN   = 10,
  parameter int              DUMP_WORDS = 36,
  parameter logic [LEN-1:0]  HALT_WORD  = 32'hFFFF_FFFF,
  parameter int              DBG_W      = $clog2(DUMP_WORDS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          rx_data,
  input  logic                rx_done,
  output logic [7:0]          tx_data,
  output logic                tx_start,
  input  logic                tx_done,
  output logic                prog_wr_en,
  output logic [ADDR_LEN-1:0] prog_addr,
  output logic [LEN-1:0]      prog_data,
  output logic                cpu_enable,
  input  logic                halt,
  output logic [DBG_W-1:0]    dbg_addr,
  input  logic [LEN-1:0]      dbg_data
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOAD      = 3'd1;
  localparam logic [2:0] S_LOAD_WR   = 3'd2;
  localparam logic [2:0] S_RUN       = 3'd3;
  localparam logic [2:0] S_STEP_IDLE = 3'd4;
  localparam logic [2:0] S_STEP_EXEC = 3'd5;
  localparam logic [2:0] S_DUMP_SEND = 3'd6;
  localparam logic [2:0] S_DUMP_WAIT = 3'd7;

  // Word index runs 0..DUMP_WORDS-1 for debug words, DUMP_WORDS for the cycle
  // count, and DUMP_WORDS+1 once every byte of the snapshot has been launched.
  localparam int                WIDX_W   = $clog2(DUMP_WORDS + 2);
  localparam logic [WIDX_W-1:0] CNT_WORD = WIDX_W'(DUMP_WORDS);
  localparam logic [WIDX_W-1:0] DONE_IDX = WIDX_W'(DUMP_WORDS + 1);

  logic [2:0]          state_q, state_d;
  logic                from_step_q, from_step_d;
  logic [1:0]          load_cnt_q, load_cnt_d;
  logic [LEN-9:0]      shift_q, shift_d;
  logic [LEN-1:0]      cycle_cnt_q, cycle_cnt_d;
  logic [WIDX_W-1:0]   word_idx_q, word_idx_d;
  logic [1:0]          byte_idx_q, byte_idx_d;
  logic [LEN-1:0]      dump_word_q, dump_word_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                tx_start_q, tx_start_d;
  logic                prog_wr_en_q, prog_wr_en_d;
  logic [ADDR_LEN-1:0] prog_addr_q, prog_addr_d;
  logic [LEN-1:0]      prog_data_q, prog_data_d;
  logic                cpu_enable_q, cpu_enable_d;
  logic [DBG_W-1:0]    dbg_addr_q, dbg_addr_d;
  logic                do_launch;
  logic [LEN-1:0]      launch_src;

  // Next-state logic: command decode, load assembly, run/step control and byte launching.
  always_comb begin
    state_d      = state_q;
    from_step_d  = from_step_q;
    load_cnt_d   = load_cnt_q;
    shift_d      = shift_q;
    cycle_cnt_d  = cycle_cnt_q;
    word_idx_d   = word_idx_q;
    byte_idx_d   = byte_idx_q;
    dump_word_d  = dump_word_q;
    tx_data_d    = tx_data_q;
    tx_start_d   = 1'b0;
    prog_wr_en_d = 1'b0;
    prog_addr_d  = prog_addr_q;
    prog_data_d  = prog_data_q;
    cpu_enable_d = 1'b0;
    dbg_addr_d   = dbg_addr_q;
    do_launch    = 1'b0;

    if (cpu_enable_q && (cycle_cnt_q != '1)) cycle_cnt_d = cycle_cnt_q + 1'b1;
    if (prog_wr_en_q) prog_addr_d = prog_addr_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (rx_done) begin
          case (rx_data)
            8'h4C: begin
              state_d     = S_LOAD;
              load_cnt_d  = 2'd0;
              prog_addr_d = '0;
            end
            8'h43: begin
              state_d      = S_RUN;
              cpu_enable_d = 1'b1;
              cycle_cnt_d  = '0;
              from_step_d  = 1'b0;
            end
            8'h53: begin
              state_d     = S_STEP_IDLE;
              cycle_cnt_d = '0;
              from_step_d = 1'b1;
            end
            default: ;
          endcase
        end
      end
      S_LOAD: begin
        if (rx_done) begin
          shift_d    = {shift_q[LEN-17:0], rx_data};
          load_cnt_d = load_cnt_q + 2'd1;
          if (load_cnt_q == 2'd3) begin
            prog_data_d = {shift_q, rx_data};
            state_d     = S_LOAD_WR;
          end
        end
      end
      S_LOAD_WR: begin
        prog_wr_en_d = 1'b1;
        state_d      = (prog_data_q == HALT_WORD) ? S_IDLE : S_LOAD;
      end
      S_RUN: begin
        if (halt) begin
          state_d   = S_DUMP_SEND;
          do_launch = 1'b1;
        end else begin
          cpu_enable_d = 1'b1;
        end
      end
      S_STEP_IDLE: begin
        if (rx_done) begin
          if (rx_data == 8'h4E) begin
            if (halt) begin
              state_d   = S_DUMP_SEND;
              do_launch = 1'b1;
            end else begin
              state_d      = S_STEP_EXEC;
              cpu_enable_d = 1'b1;
            end
          end else if (rx_data == 8'h45) begin
            state_d = S_IDLE;
          end
        end
      end
      S_STEP_EXEC: begin
        state_d   = S_DUMP_SEND;
        do_launch = 1'b1;
      end
      S_DUMP_SEND: begin
        state_d = S_DUMP_WAIT;
      end
      S_DUMP_WAIT: begin
        if (tx_done) begin
          if (word_idx_q == DONE_IDX) begin
            word_idx_d = '0;
            state_d    = from_step_q ? S_STEP_IDLE : S_IDLE;
          end else begin
            state_d   = S_DUMP_SEND;
            do_launch = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A word's first byte latches the live debug word (or the cycle count);
    // later bytes shift out of the latched copy so the word stays coherent.
    if (byte_idx_q == 2'd0) begin
      launch_src = (word_idx_q < CNT_WORD) ? dbg_data : cycle_cnt_q;
    end else begin
      launch_src = dump_word_q;
    end

    if (do_launch) begin
      tx_start_d  = 1'b1;
      tx_data_d   = launch_src[LEN-1 -: 8];
      dump_word_d = launch_src << 8;
      byte_idx_d  = byte_idx_q + 2'd1;
      if (byte_idx_q == 2'd3) word_idx_d = word_idx_q + 1'b1;
      if ((byte_idx_q == 2'd0) && (word_idx_q < CNT_WORD)) begin
        dbg_addr_d = (word_idx_q == CNT_WORD - 1'b1) ? '0 : DBG_W'(word_idx_q + 1'b1);
      end
    end
  end

  // State and registered outputs; reset aborts any load or dump in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      from_step_q  <= 1'b0;
      load_cnt_q   <= 2'd0;
      shift_q      <= '0;
      cycle_cnt_q  <= '0;
      word_idx_q   <= '0;
      byte_idx_q   <= 2'd0;
      dump_word_q  <= '0;
      tx_data_q    <= 8'd0;
      tx_start_q   <= 1'b0;
      prog_wr_en_q <= 1'b0;
      prog_addr_q  <= '0;
      prog_data_q  <= '0;
      cpu_enable_q <= 1'b0;
      dbg_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      from_step_q  <= from_step_d;
      load_cnt_q   <= load_cnt_d;
      shift_q      <= shift_d;
      cycle_cnt_q  <= cycle_cnt_d;
      word_idx_q   <= word_idx_d;
      byte_idx_q   <= byte_idx_d;
      dump_word_q  <= dump_word_d;
      tx_data_q    <= tx_data_d;
      tx_start_q   <= tx_start_d;
      prog_wr_en_q <= prog_wr_en_d;
      prog_addr_q  <= prog_addr_d;
      prog_data_q  <= prog_data_d;
      cpu_enable_q <= cpu_enable_d;
      dbg_addr_q   <= dbg_addr_d;
    end
  end

  assign tx_data    = tx_data_q;
  assign tx_start   = tx_start_q;
  assign prog_wr_en = prog_wr_en_q;
  assign prog_addr  = prog_addr_q;
  assign prog_data  = prog_data_q;
  assign cpu_enable = cpu_enable_q;
  assign dbg_addr   = dbg_addr_q;

endmodule

// File: tb/tb_mips_debug_unit.sv
// Testbench for mips_debug_unit: directed command sequences with randomized
// program words, debug contents, halt timing and transmitter latency.
module tb_mips_debug_unit;

  localparam int DUMP_WORDS = 36;
  localparam int BYTES      = 4 * (DUMP_WORDS + 1);

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_done;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_done = 1'b0;
  logic        prog_wr_en;
  logic [9:0]  prog_addr;
  logic [31:0] prog_data;
  logic        cpu_enable;
  logic        halt;
  logic [5:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic [31:0] dbg_mem [64];

  int checks = 0;
  int failures = 0;

  int cyc = 0;
  int en_high_cnt = 0;
  int en_pulse_cnt = 0;
  int gap_bad = 0;
  int extra_start = 0;
  int tx_total = 0;
  int pend_cnt = 0;
  int last_done_cyc = 0;
  int tx_delay = 2;
  logic en_prev = 1'b0;
  logic pend = 1'b0;
  logic done_valid = 1'b0;
  logic [7:0]  tx_q [$];
  logic [41:0] wr_q [$];

  mips_debug_unit dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done(rx_done),
    .tx_data(tx_data), .tx_start(tx_start), .tx_done(tx_done),
    .prog_wr_en(prog_wr_en), .prog_addr(prog_addr), .prog_data(prog_data),
    .cpu_enable(cpu_enable), .halt(halt), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  assign dbg_data = dbg_mem[dbg_addr];

  always #5 clk = ~clk;

  // Observer and UART transmitter stand-in: logs writes, bytes and enable
  // cycles, and answers each tx_start with tx_done after tx_delay cycles.
  always @(negedge clk) begin
    cyc++;
    if (prog_wr_en) wr_q.push_back({prog_addr, prog_data});
    if (cpu_enable) en_high_cnt++;
    if (cpu_enable && !en_prev) en_pulse_cnt++;
    en_prev = cpu_enable;
    tx_done = 1'b0;
    if (pend) begin
      if (pend_cnt >= tx_delay) begin
        tx_done = 1'b1;
        pend = 1'b0;
        last_done_cyc = cyc;
        done_valid = (tx_total % BYTES) != 0;
      end else begin
        pend_cnt++;
      end
    end
    if (tx_start) begin
      if (pend) extra_start++;
      if (done_valid && (cyc != last_done_cyc + 1)) gap_bad++;
      done_valid = 1'b0;
      tx_q.push_back(tx_data);
      tx_total++;
      pend = 1'b1;
      pend_cnt = 0;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] out_bits();
    return {5'b0, tx_start, prog_wr_en, cpu_enable, tx_data, prog_addr, prog_data, dbg_addr};
  endfunction

  task automatic applyStimulus(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic sendWord(input logic [31:0] w);
    for (int b = 0; b < 4; b++) applyStimulus(w[31-8*b -: 8]);
  endtask

  task automatic waitTx(input int target, input string tag);
    int n = 0;
    while (tx_q.size() < target && n < 5000) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_wait"}, 64'(tx_q.size() >= target), 64'd1);
  endtask

  // Expected snapshot: every debug word in address order, then the cycle count.
  task automatic waitDump(input int base, input logic [31:0] exp_cnt, input string tag);
    int n = 0;
    int bad = 0;
    logic [31:0] last_word;
    logic [7:0]  e;
    while (tx_q.size() < base + BYTES && n < 20000) begin
      @(negedge clk);
      n++;
    end
    repeat (30) @(negedge clk);
    checkOutput({tag, "_bytes"}, 64'(tx_q.size() - base), 64'(BYTES));
    last_word = '0;
    if (tx_q.size() >= base + BYTES) begin
      for (int i = 0; i < BYTES; i++) begin
        if (i < 4 * DUMP_WORDS) begin
          e = dbg_mem[i / 4][31 - 8 * (i % 4) -: 8];
        end else begin
          e = exp_cnt[31 - 8 * (i % 4) -: 8];
        end
        if (tx_q[base + i] !== e) bad++;
      end
      last_word = {tx_q[base+BYTES-4], tx_q[base+BYTES-3], tx_q[base+BYTES-2], tx_q[base+BYTES-1]};
    end else begin
      bad = BYTES;
    end
    checkOutput({tag, "_data_bad"}, 64'(bad), 64'd0);
    checkOutput({tag, "_cycles"}, 64'(last_word), 64'(exp_cnt));
  endtask

  task automatic runContinuous(input int k, input bit backpressure, input string tag);
    int eh, wb, tb;
    foreach (dbg_mem[i]) dbg_mem[i] = $urandom;
    tx_delay = backpressure ? 5000 : int'($urandom_range(0, 4));
    eh = en_high_cnt;
    wb = wr_q.size();
    tb = tx_q.size();
    applyStimulus(8'h43);
    checkOutput({tag, "_en_rise"}, 64'(cpu_enable), 64'd1);
    for (int i = 1; i <= k; i++) begin
      @(negedge clk);
      if (i == 3) begin
        rx_data = 8'h4C;
        rx_done = 1'b1;
      end
      if (i == 4) rx_done = 1'b0;
      if (i == k) halt = 1'b1;
    end
    @(negedge clk);
    checkOutput({tag, "_en_fall"}, 64'(cpu_enable), 64'd0);
    if (backpressure) begin
      waitTx(tb + 1, {tag, "_first"});
      repeat (1000) @(negedge clk);
      checkOutput({tag, "_bp_hold"}, 64'(tx_q.size() - tb), 64'd1);
      tx_delay = 1;
    end else begin
      waitTx(tb + 2, {tag, "_second"});
      applyStimulus(8'h4C);
      applyStimulus(8'h4E);
    end
    waitDump(tb, 32'(k + 1), tag);
    checkOutput({tag, "_en_cycles"}, 64'(en_high_cnt - eh), 64'(k + 1));
    checkOutput({tag, "_no_write"}, 64'(wr_q.size() - wb), 64'd0);
    halt = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    int wb, tb, eh, ep, n, bad, sz;
    logic [31:0] w;
    logic [31:0] words [$];

    reset = 1'b0;
    rx_done = 1'b0;
    rx_data = 8'd0;
    halt = 1'b0;
    foreach (dbg_mem[i]) dbg_mem[i] = $urandom;
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs", out_bits(), 64'd0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("post_reset_outputs", out_bits(), 64'd0);

    // Unknown bytes and step-only commands in IDLE do nothing.
    wb = wr_q.size(); tb = tx_q.size(); eh = en_high_cnt;
    applyStimulus(8'h7A);
    applyStimulus(8'h4E);
    applyStimulus(8'h45);
    applyStimulus(8'($urandom_range(0, 8'h42)));
    repeat (10) @(negedge clk);
    checkOutput("idle_filter_wr", 64'(wr_q.size() - wb), 64'd0);
    checkOutput("idle_filter_tx", 64'(tx_q.size() - tb), 64'd0);
    checkOutput("idle_filter_en", 64'(en_high_cnt - eh), 64'd0);

    // Three-word load ending in the halt word.
    wb = wr_q.size();
    applyStimulus(8'h4C);
    sendWord(32'h0000_0001);
    checkOutput("load_wr_t1", 64'(prog_wr_en), 64'd0);
    @(negedge clk);
    checkOutput("load_wr_t2", 64'({prog_wr_en, prog_addr, prog_data}), 64'({1'b1, 10'd0, 32'd1}));
    sendWord(32'h0000_0002);
    sendWord(32'hFFFF_FFFF);
    repeat (5) @(negedge clk);
    checkOutput("load_count", 64'(wr_q.size() - wb), 64'd3);
    if (wr_q.size() >= wb + 3) begin
      checkOutput("load_w0", 64'(wr_q[wb]),     64'({10'd0, 32'h1}));
      checkOutput("load_w1", 64'(wr_q[wb + 1]), 64'({10'd1, 32'h2}));
      checkOutput("load_w2", 64'(wr_q[wb + 2]), 64'({10'd2, 32'hFFFF_FFFF}));
    end

    // Long random load that wraps the 10-bit address.
    wb = wr_q.size();
    n = 1025;
    applyStimulus(8'h4C);
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      if (w == 32'hFFFF_FFFF) w = 32'd0;
      words.push_back(w);
      sendWord(w);
    end
    words.push_back(32'hFFFF_FFFF);
    sendWord(32'hFFFF_FFFF);
    repeat (5) @(negedge clk);
    checkOutput("wrap_count", 64'(wr_q.size() - wb), 64'(n + 1));
    bad = 0;
    for (int i = 0; i <= n; i++) begin
      if (wb + i >= wr_q.size()) bad++;
      else if (wr_q[wb + i] !== {10'(i % 1024), words[i]}) bad++;
    end
    checkOutput("wrap_bad", 64'(bad), 64'd0);
    checkOutput("wrap_final_addr", 64'(prog_addr), 64'((n + 1) % 1024));

    // Continuous runs: fixed halt point, then random halt with transmitter backpressure.
    runContinuous(10, 1'b0, "run10");
    runContinuous(int'($urandom_range(6, 40)), 1'b1, "run_bp");

    // Step mode: two steps, a step attempt while halted, then exit.
    tx_delay = int'($urandom_range(0, 4));
    applyStimulus(8'h53);
    repeat (3) @(negedge clk);
    for (int s = 1; s <= 2; s++) begin
      foreach (dbg_mem[i]) dbg_mem[i] = $urandom;
      ep = en_pulse_cnt; eh = en_high_cnt; tb = tx_q.size();
      applyStimulus(8'h4E);
      checkOutput("step_t1", 64'({cpu_enable, tx_start}), 64'd2);
      @(negedge clk);
      checkOutput("step_t2", 64'({cpu_enable, tx_start}), 64'd1);
      waitDump(tb, 32'(s), "step");
      checkOutput("step_en_cycles", 64'(en_high_cnt - eh), 64'd1);
      checkOutput("step_en_pulses", 64'(en_pulse_cnt - ep), 64'd1);
    end
    halt = 1'b1;
    eh = en_high_cnt; tb = tx_q.size();
    applyStimulus(8'h4E);
    waitDump(tb, 32'd2, "step_halted");
    checkOutput("step_halted_en", 64'(en_high_cnt - eh), 64'd0);
    halt = 1'b0;
    applyStimulus(8'h45);
    repeat (5) @(negedge clk);
    eh = en_high_cnt; tb = tx_q.size();
    applyStimulus(8'h4E);
    repeat (10) @(negedge clk);
    checkOutput("exit_idle_en", 64'(en_high_cnt - eh), 64'd0);
    checkOutput("exit_idle_tx", 64'(tx_q.size() - tb), 64'd0);

    // Reset halfway through a load word discards it.
    applyStimulus(8'h4C);
    applyStimulus(8'h12);
    applyStimulus(8'h34);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("reset_mid_load", out_bits(), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    wb = wr_q.size();
    applyStimulus(8'h4C);
    sendWord(32'hFFFF_FFFF);
    repeat (5) @(negedge clk);
    checkOutput("reload_count", 64'(wr_q.size() - wb), 64'd1);
    if (wr_q.size() > wb) checkOutput("reload_word", 64'(wr_q[wb]), 64'({10'd0, 32'hFFFF_FFFF}));

    // Reset in the middle of a dump stops transmission at once.
    tx_delay = 3;
    halt = 1'b1;
    tb = tx_q.size();
    wb = wr_q.size();
    applyStimulus(8'h43);
    waitTx(tb + 3, "mid_dump");
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("reset_mid_dump", out_bits(), 64'd0);
    sz = tx_q.size();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    halt = 1'b0;
    repeat (100) @(negedge clk);
    checkOutput("after_reset_tx", 64'(tx_q.size() - sz), 64'd0);
    checkOutput("after_reset_wr", 64'(wr_q.size() - wb), 64'd0);

    checkOutput("tx_gap", 64'(gap_bad), 64'd0);
    checkOutput("tx_extra", 64'(extra_start), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
